// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the external byte-wide RAM arbiter: FSM states,
// request owners, size codes and the default IO-space address bit.
package mem_arbiter_pkg;

    localparam int unsigned IO_ADDR_BIT_DEFAULT = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_LSB
    } owner_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_WIDE = 2'd3
    } size_t;

    // Byte count for a size code; code 3 behaves as a word.
    function automatic logic [2:0] size_to_n(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_seq.sv
// mem_byte_seq: byte counter, base+offset address generation and the
// little-endian read-assembly register used by mem_arbiter.
// The counter is the byte offset to issue next; during reads the byte
// arriving on mem_din belongs to offset (count - 2).
module mem_byte_seq
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [2:0]        start_n_i,
    input  logic              start_issued_i,
    input  logic              step_i,
    input  logic              cap_i,
    input  logic [7:0]        mem_din_i,
    output logic [2:0]        cnt_o,
    output logic [2:0]        n_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       asm_o
);

    logic [ADDR_W-1:0] base_q;
    logic [2:0]        cnt_q;
    logic [2:0]        n_q;
    logic [31:0]       asm_q;
    logic [1:0]        lane;

    assign lane   = cnt_q[1:0] - 2'd2;
    assign cnt_o  = cnt_q;
    assign n_o    = n_q;
    assign addr_o = base_q + {{(ADDR_W-3){1'b0}}, cnt_q};

    // Assembled word including the byte currently on mem_din.
    always_comb begin
        asm_o = asm_q;
        asm_o[{lane, 3'b000} +: 8] = mem_din_i;
    end

    // Counter, base address and assembly register; frozen while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            base_q <= '0;
            cnt_q  <= '0;
            n_q    <= '0;
            asm_q  <= '0;
        end else if (rdy_in) begin
            if (start_i) begin
                base_q <= start_addr_i;
                n_q    <= start_n_i;
                cnt_q  <= start_issued_i ? 3'd1 : 3'd0;
                asm_q  <= '0;
            end else begin
                if (step_i) cnt_q <= cnt_q + 3'd1;
                if (cap_i)  asm_q <= asm_o;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: owns the byte-wide RAM port, round-robin arbitrates fetch vs
// load/store, splits 1/2/4-byte requests into byte transactions and
// reassembles little-endian read data.
// Optional build macro MEM_IO_STALL_EN: IO-space store bytes wait while
// io_buffer_full is high.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned IO_ADDR_BIT = IO_ADDR_BIT_DEFAULT
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_welcome,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_t            state_q;
    owner_t            owner_q;      // also serves as last_grant
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] mem_a_q;
    logic [7:0]        dout_q;
    logic              wr_q;
    logic              if_done_q, ls_done_q;
    logic [31:0]       if_data_q, ls_rdata_q;

    logic              grant_if, grant_ls, start;
    logic [ADDR_W-1:0] start_addr_d;
    logic              start_we_d;
    logic              stall_start, stall_step;
    logic              seq_step, seq_cap;
    logic [2:0]        seq_cnt, seq_n;
    logic [ADDR_W-1:0] seq_addr;
    logic [31:0]       seq_asm;

    // Round-robin grant: on contention the owner opposite last_grant wins.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (if_req && ls_req) begin
            if (owner_q == OWN_FETCH) grant_ls = 1'b1;
            else                      grant_if = 1'b1;
        end else if (ls_req) begin
            grant_ls = 1'b1;
        end else if (if_req) begin
            grant_if = 1'b1;
        end
    end

    assign start        = (state_q == ST_IDLE) && !flush_in && (grant_if || grant_ls);
    assign start_addr_d = grant_ls ? ls_addr : if_addr;
    assign start_we_d   = grant_ls && ls_we;

`ifdef MEM_IO_STALL_EN
    assign stall_start = start_we_d && (start_addr_d[IO_ADDR_BIT -: 2] == 2'b11) && io_buffer_full;
    assign stall_step  = (seq_addr[IO_ADDR_BIT -: 2] == 2'b11) && io_buffer_full;
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign stall_start    = 1'b0;
    assign stall_step     = 1'b0;
`endif

    assign seq_step = ((state_q == ST_READ) && !flush_in)
                   || ((state_q == ST_WRITE) && (seq_cnt < seq_n) && !stall_step);
    assign seq_cap  = (state_q == ST_READ) && !flush_in && (seq_cnt >= 3'd2);

    mem_byte_seq #(.ADDR_W(ADDR_W)) u_seq (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .rdy_in         (rdy_in),
        .start_i        (start),
        .start_addr_i   (start_addr_d),
        .start_n_i      (grant_ls ? size_to_n(ls_size) : 3'd4),
        .start_issued_i (!(start_we_d && stall_start)),
        .step_i         (seq_step),
        .cap_i          (seq_cap),
        .mem_din_i      (mem_din),
        .cnt_o          (seq_cnt),
        .n_o            (seq_n),
        .addr_o         (seq_addr),
        .asm_o          (seq_asm)
    );

    // Transaction FSM with registered RAM-side and requester-side outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_FETCH;
            wdata_q    <= '0;
            mem_a_q    <= '0;
            dout_q     <= '0;
            wr_q       <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else if (rdy_in) begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        owner_q <= grant_ls ? OWN_LSB : OWN_FETCH;
                        wdata_q <= ls_wdata;
                        mem_a_q <= start_addr_d;
                        dout_q  <= ls_wdata[7:0];
                        if (start_we_d) begin
                            wr_q    <= !stall_start;
                            state_q <= ST_WRITE;
                        end else begin
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (flush_in) begin
                        state_q <= ST_IDLE;
                    end else begin
                        if (seq_cnt < seq_n) mem_a_q <= seq_addr;
                        if (seq_cnt == seq_n + 3'd1) begin
                            if (owner_q == OWN_FETCH) begin
                                if_data_q <= seq_asm;
                                if_done_q <= 1'b1;
                            end else begin
                                ls_rdata_q <= seq_asm;
                                ls_done_q  <= 1'b1;
                            end
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_WRITE: begin
                    // Flush is ignored here: the store is already committed.
                    if (seq_cnt < seq_n) begin
                        if (stall_step) begin
                            wr_q <= 1'b0;
                        end else begin
                            mem_a_q <= seq_addr;
                            dout_q  <= wdata_q[{seq_cnt[1:0], 3'b000} +: 8];
                            wr_q    <= 1'b1;
                        end
                    end else begin
                        wr_q <= 1'b0;
                        if (owner_q == OWN_FETCH) if_done_q <= 1'b1;
                        else                      ls_done_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign if_done    = if_done_q;
    assign if_data    = if_data_q;
    assign ls_done    = ls_done_q;
    assign ls_rdata   = ls_rdata_q;
    assign ls_welcome = (state_q == ST_IDLE);
    assign mem_a      = mem_a_q;
    assign mem_dout   = dout_q;
    assign mem_wr     = wr_q & rdy_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte-addressed RAM with one-cycle read
// latency, a transaction-level memory model, directed and random traffic.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [1:0]  ls_size = '0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_welcome, ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_full = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .IO_ADDR_BIT(17)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_welcome(ls_welcome), .ls_done(ls_done),
        .ls_rdata(ls_rdata), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_full)
    );

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            0: return 8'h13;
            1: return 8'h05;
            2, 3: return 8'h00;
            default: return 8'(i * 29 + 7);
        endcase
    endfunction

    // External RAM: 1 KiB aliased, registered read, paused by rdy.
    logic [7:0] ram [0:1023];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_byte(i);
            mem_din <= 8'h00;
        end else begin
            if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
            if (rdy) mem_din <= ram[mem_a[9:0]];
        end
    end

    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
    wr_t wq[$];
    bit  both_done = 1'b0;
    always @(negedge clk) begin
        if (mem_wr) wq.push_back('{mem_a, mem_dout});
        if (if_done && ls_done) both_done <= 1'b1;
    end

    logic [7:0] model [0:1023];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int n_of(input bit is_fetch, input logic [1:0] sz);
        if (is_fetch || sz >= 2) return 4;
        return (sz == 0) ? 1 : 2;
    endfunction

    task automatic run_txn(input bit is_fetch, input bit we, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int pause_at, input int flush_at,
                           output logic [31:0] rdata);
        int n, lat, edges, base;
        bit got;
        logic [31:0] exp_rd, a;
        n = n_of(is_fetch, sz);
        exp_rd = '0;
        for (int k = 0; k < n; k++) begin
            a = addr + k;
            exp_rd[8*k +: 8] = model[a[9:0]];
        end
        lat = (we ? n : n + 1) + ((pause_at > 0) ? 2 : 0);
        base = wq.size();
        @(negedge clk);
        if (is_fetch) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = addr; ls_wdata = wdata;
        end
        @(posedge clk);
        edges = 0; got = 1'b0; rdata = '0;
        while (!got && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (is_fetch ? if_done : ls_done) begin
                got = 1'b1;
                rdata = is_fetch ? if_data : ls_rdata;
            end else begin
                if (pause_at > 0 && edges == pause_at) rdy = 1'b0;
                if (pause_at > 0 && edges == pause_at + 2) rdy = 1'b1;
                if (flush_at > 0 && edges == flush_at) flush = 1'b1;
                if (flush_at > 0 && edges == flush_at + 1) flush = 1'b0;
            end
        end
        if_req = 1'b0; ls_req = 1'b0; rdy = 1'b1; flush = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        check("latency", edges, lat);
        if (we) begin
            check("wr_count", wq.size() - base, n);
            for (int k = 0; k < n; k++) begin
                a = addr + k;
                if (base + k < wq.size()) begin
                    check("wr_addr", wq[base + k].a, a);
                    check("wr_data", 32'(wq[base + k].d), 32'(wdata[8*k +: 8]));
                end
                model[a[9:0]] = wdata[8*k +: 8];
            end
        end else begin
            check("rd_data", rdata, exp_rd);
            check("rd_nowrite", wq.size() - base, 0);
        end
        @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, exp_ls, exp_if, ls_val, if_val, a, wa;
        int edges, ls_edge, if_edge, base, first_wr, done_e, n, bl, p, fl;
        bit seen, f, w;
        logic [1:0] sz;
        logic [7:0] wd;

        for (int i = 0; i < 1024; i++) model[i] = init_byte(i);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_if_done", 32'(if_done), 0);
        check("rst_ls_done", 32'(ls_done), 0);
        check("rst_mem_wr", 32'(mem_wr), 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_welcome", 32'(ls_welcome), 1);
        check("rst_if_data", if_data, 0);
        @(negedge clk) rst_n = 1'b1;

        // Simultaneous requests after reset: LSB first, then fetch
        exp_ls = {model[16'h43], model[16'h42], model[16'h41], model[16'h40]};
        exp_if = {model[16'h83], model[16'h82], model[16'h81], model[16'h80]};
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h80;
        @(posedge clk);
        edges = 0; ls_edge = 0; if_edge = 0; ls_val = '0; if_val = '0;
        while (if_edge == 0 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (ls_done && ls_edge == 0) begin ls_edge = edges; ls_val = ls_rdata; end
            if (if_done) begin if_edge = edges; if_val = if_data; end
        end
        if_req = 1'b0; ls_req = 1'b0;
        check("arb_ls_first", ls_edge, 5);
        check("arb_if_second", if_edge, 12);
        check("arb_ls_data", ls_val, exp_ls);
        check("arb_if_data", if_val, exp_if);
        @(posedge clk);

        // Fetch of 0x1000 (aliases RAM bytes 13 05 00 00)
        run_txn(1'b1, 1'b0, 2'd2, 32'h1000, '0, 0, 0, rd);
        check("fetch_word", rd, 32'h0000_0513);

        // Half store 0xBEEF to 0x20
        run_txn(1'b0, 1'b1, 2'd1, 32'h20, 32'h0000_BEEF, 0, 0, rd);
        run_txn(1'b0, 1'b0, 2'd1, 32'h20, '0, 0, 0, rd);
        check("half_readback", rd, 32'h0000_BEEF);

        // Word load flushed at the capture of byte 2
        base = wq.size();
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h100;
        @(posedge clk); #1;
        check("busy_welcome", 32'(ls_welcome), 0);
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        check("flush_rd_idle", 32'(ls_welcome), 1);
        flush = 1'b0; ls_req = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ls_done) seen = 1'b1;
        end
        check("flush_rd_nodone", 32'(seen), 0);
        check("flush_rd_nowr", wq.size() - base, 0);

        // Flush in IDLE beats a pending load
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h10; flush = 1'b1;
        @(posedge clk); #1;
        check("flush_idle_nogrant", 32'(ls_welcome), 1);
        ls_req = 1'b0; flush = 1'b0;
        @(posedge clk);

        // Store flushed mid-way still completes all bytes
        run_txn(1'b0, 1'b1, 2'd2, 32'h60, 32'hCAFE_F00D, 0, 2, rd);

        // rdy low for 2 cycles mid word-read
        run_txn(1'b1, 1'b0, 2'd2, 32'h60, '0, 2, 0, rd);
        check("pause_data", rd, 32'hCAFE_F00D);

        // IO-space byte store with the UART buffer full for 3 cycles
        io_full = 1'b1;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h0003_0000; ls_wdata = 32'h41;
        edges = 0; first_wr = 0; done_e = 0; wa = '0; wd = '0;
        while (done_e == 0 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (mem_wr && first_wr == 0) begin first_wr = edges; wa = mem_a; wd = mem_dout; end
            if (ls_done) done_e = edges;
            if (edges == 3) io_full = 1'b0;
        end
        ls_req = 1'b0; io_full = 1'b0;
        model[0] = 8'h41;
`ifdef MEM_IO_STALL_EN
        check("io_first_wr", first_wr, 4);
        check("io_done", done_e, 5);
`else
        check("io_first_wr", first_wr, 1);
        check("io_done", done_e, 2);
`endif
        check("io_wr_addr", wa, 32'h0003_0000);
        check("io_wr_data", 32'(wd), 32'h41);
        @(posedge clk);

        // Random traffic against the memory model
        for (int t = 0; t < 40; t++) begin
            f  = ($urandom_range(0, 2) == 0);
            w  = !f && ($urandom_range(0, 1) == 1);
            sz = 2'($urandom_range(0, 3));
            a  = (t % 8 == 7) ? 32'hFFFF_FFFD : $urandom;
            n  = n_of(f, sz);
            bl = w ? n : n + 1;
            p  = (bl > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, bl - 1)) : 0;
            fl = (w && n > 1 && p == 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, n - 1)) : 0;
            run_txn(f, w, sz, a, $urandom, p, fl, rd);
        end

        check("done_exclusive", 32'(both_done), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
